serial_adder_ctrl: RTL



---
 rtl/serial_add_pkg.sv | 15 +
 rtl/full_adder_bit.sv | 31 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and sizing helper for the bit-serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Bit-index counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - one-bit full adder built from two half adders
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a  (a),
        .b  (b),
        .s  (s0),
        .co (c0)
    );

    half_adder u_ha1 (
        .a  (s0),
        .b  (cin),
        .s  (s),
        .co (c1)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder cell
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);

    assign s  = a ^ b;
    assign co = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencing one shared full-adder cell LSB-first
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] idx;
    logic             cell_s;
    logic             cell_co;
    logic             last_bit;

    assign last_bit = (idx == CNT_W'(WIDTH - 1));

    full_adder_bit u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (cell_s),
        .co  (cell_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, run WIDTH bit cycles, then one DONE cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start)    state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            ST_IDLE: ready = 1'b1;
            ST_RUN:  busy  = 1'b1;
            ST_DONE: done  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, per-bit shifting, and result commit on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        acc   <= '0;
                        carry <= 1'b0;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    acc   <= {cell_s, acc[WIDTH-1:1]};
                    carry <= cell_co;
                    idx   <= idx + 1'b1;
                    // The final bit lands in the MSB, so commit the shifted value, not acc.
                    if (last_bit) begin
                        sum  <= {cell_s, acc[WIDTH-1:1]};
                        cout <= cell_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
